// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port: each requester owns the
// port for up to BURST_MAX beats, then ownership rotates to the next requester.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int BURST_MAX = 4,
    localparam int OW       = (N > 1) ? $clog2(N) : 1,
    localparam int CW       = $clog2(BURST_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     gnt,
    input  logic             fifo_full,
    output logic             fifo_write_enable,
    output logic [W-1:0]     fifo_data_in,
    output logic [OW-1:0]    owner,
    output logic             busy,
    output logic [15:0]      wr_count
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   owner_nxt, last, last_nxt, base, pick, idx;
    logic [CW-1:0]   beat_cnt, beat_nxt;
    logic            any_req, xfer, exit_burst;

    assign busy    = (state == BURST);
    assign any_req = |req;

    // Per-requester grant: only the current owner may move a beat, and only
    // when the FIFO can take it.
    for (genvar i = 0; i < N; i++) begin : g_gnt
        assign gnt[i] = busy && (owner == OW'(i)) && req[i] && !fifo_full;
    end

    assign xfer              = |gnt;
    assign fifo_write_enable = xfer;
    assign fifo_data_in      = xfer ? req_data[int'(owner)*W +: W] : '0;

    // Search base+1 .. base+N; iterating downward lets the nearest hit win,
    // so base itself ends up lowest priority.
    always_comb begin
        base = busy ? owner : last;
        pick = base;
        idx  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = OW'((int'(base) + k) % N);
            if (req[idx]) pick = idx;
        end
    end

    assign exit_burst = !req[owner] || (xfer && (beat_cnt == CW'(BURST_MAX - 1)));

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BURST;
                    owner_nxt = pick;
                    last_nxt  = pick;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                if (xfer) beat_nxt = beat_cnt + 1'b1;
                if (exit_burst) begin
                    beat_nxt = '0;
                    if (any_req) begin
                        owner_nxt = pick;
                        last_nxt  = pick;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= OW'(N - 1);
            beat_cnt <= '0;
            wr_count <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_nxt;
            if (xfer) wr_count <= wr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: requester agents feed beat queues, a
// tenure-level arbitration model predicts writes, a monitor scoreboards them.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BM = 4;
    localparam int OW = 2;

    logic             clk, rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic             fifo_full, fifo_write_enable;
    logic [W-1:0]     fifo_data_in;
    logic [OW-1:0]    owner;
    logic             busy;
    logic [15:0]      wr_count;

    fifo_wr_arbiter #(.N(N), .W(W), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_write_enable(fifo_write_enable),
        .fifo_data_in(fifo_data_in), .owner(owner), .busy(busy), .wr_count(wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int owner; logic [W-1:0] data; } exp_t;
    exp_t exp_q[$];
    int   wlog[$];
    int   wcyc[$];
    int   checks = 0, failures = 0, cyc = 0;

    // requester agents: beat queues as ring buffers
    logic [W-1:0] bq [N][256];
    int           hd[N], tl[N], rate[N];
    int           full_rate;
    logic [N-1:0] gnt_s;

    // arbitration model: who holds the port, how many beats into the tenure
    bit          m_busy, cur_busy;
    int          m_owner, m_last, m_beats, cur_owner;
    logic [15:0] m_wr, cur_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int b, input logic [N-1:0] r);
        for (int d = 1; d <= N; d++)
            if (r[(b + d) % N]) return (b + d) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = N - 1; m_beats = 0; m_wr = '0;
        cur_busy = 0; cur_owner = 0; cur_wr = '0;
    endtask

    // Decide what happens at the coming edge from the inputs presented now.
    task automatic model_step();
        int  p;
        bit  done;
        exp_t e;
        cur_busy = m_busy; cur_owner = m_owner; cur_wr = m_wr;
        if (!m_busy) begin
            p = rr_pick(m_last, req);
            if (p >= 0) begin
                m_busy = 1; m_owner = p; m_last = p; m_beats = 0;
            end
        end else begin
            done = 0;
            if (req[m_owner] && !fifo_full) begin
                e.owner = m_owner;
                e.data  = req_data[m_owner*W +: W];
                exp_q.push_back(e);
                m_beats++;
                m_wr = m_wr + 16'd1;
                if (m_beats == BM) done = 1;
            end
            if (!req[m_owner]) done = 1;
            if (done) begin
                p = rr_pick(m_owner, req);
                m_beats = 0;
                if (p < 0) m_busy = 0;
                else begin m_owner = p; m_last = p; end
            end
        end
    endtask

    task automatic fill(input int i, input int n, input int seq_base);
        for (int k = 0; k < n; k++) begin
            bq[i][tl[i] % 256] = (seq_base >= 0) ? W'(seq_base + k) : W'($urandom);
            tl[i]++;
        end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (req[i] && gnt_s[i]) begin
                hd[i]++;
                req[i] = 1'b0;
            end
            if (!req[i] && (tl[i] > hd[i]) && ($urandom_range(99) < rate[i])) req[i] = 1'b1;
            if (req[i]) req_data[i*W +: W] = bq[i][hd[i] % 256];
        end
        fifo_full = ($urandom_range(99) < full_rate);
        #1;
        model_step();
    endtask

    task automatic drain(input string name);
        int  g = 0;
        bit  empty;
        full_rate = 0;
        forever begin
            empty = 1;
            for (int i = 0; i < N; i++) if (tl[i] > hd[i]) empty = 0;
            if (empty && req == '0 && !m_busy && !cur_busy) break;
            if (g >= 3000) begin
                checks++; failures++;
                $display("FAIL %s_timeout actual=%0d cycles required=drained", name, g);
                break;
            end
            cycle();
            g++;
        end
        repeat (2) cycle();
    endtask

    task automatic rst_checks(input string name);
        chk({name, "_gnt"}, 32'(gnt), 0);
        chk({name, "_we"}, 32'(fifo_write_enable), 0);
        chk({name, "_data"}, 32'(fifo_data_in), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_owner"}, 32'(owner), 0);
        chk({name, "_wr_count"}, 32'(wr_count), 0);
    endtask

    // Called at +2 after an edge; asserts reset between edges.
    task automatic do_reset(input string name);
        #1 rst = 1'b1;
        #1 rst_checks(name);
        req = '0; fifo_full = 1'b0;
        exp_q.delete();
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin
        exp_t e;
        int   go;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                gnt_s = '0;
            end else begin
                gnt_s = gnt;
                chk("gnt_onehot", 32'((gnt & (gnt - 1'b1)) == '0), 1);
                if (fifo_full) chk("write_while_full", 32'(fifo_write_enable), 0);
                chk("busy", 32'(busy), 32'(cur_busy));
                chk("owner", 32'(owner), 32'(cur_owner));
                chk("wr_count", 32'(wr_count), 32'(cur_wr));
                if (fifo_write_enable) begin
                    go = -1;
                    for (int i = 0; i < N; i++) if (gnt[i]) go = i;
                    wlog.push_back(go);
                    wcyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write actual=data %0h owner %0d required=no write", fifo_data_in, go);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_data", 32'(fifo_data_in), 32'(e.data));
                        chk("wr_gnt", 32'(gnt), 32'(1) << e.owner);
                    end
                end else begin
                    chk("idle_data_zero", 32'(fifo_data_in), 0);
                end
            end
        end
    end

    initial begin
        int g;
        rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; gnt_s = '0; full_rate = 0;
        for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; rate[i] = 100; end
        model_reset();
        #1 rst_checks("reset");
        @(posedge clk); #1 rst = 1'b0;

        // single requester, 5 beats, re-granted after BURST_MAX
        fill(0, 5, 'h11);
        wlog.delete(); wcyc.delete();
        drain("single");
        chk("single_wr_count", 32'(wr_count), 5);
        chk("single_writes", 32'(wlog.size()), 5);
        if (wcyc.size() == 5) chk("single_no_bubble", 32'(wcyc[4] - wcyc[0]), 4);

        // all four requesting: strict rotation, 4 beats each, no idle cycles
        do_reset("rst_b");
        for (int i = 0; i < N; i++) fill(i, 8, 16 * i);
        wlog.delete(); wcyc.delete();
        drain("rotate");
        chk("rotate_writes", 32'(wlog.size()), 32);
        if (wlog.size() == 32) begin
            for (int k = 0; k < 32; k++) chk($sformatf("rotate_owner%0d", k), 32'(wlog[k]), 32'((k / BM) % N));
            chk("rotate_no_idle", 32'(wcyc[31] - wcyc[0]), 31);
        end

        // random traffic with FIFO backpressure and early drops
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                fill(i, $urandom_range(0, 9), -1);
                rate[i] = $urandom_range(20, 100);
            end
            full_rate = $urandom_range(0, 40);
            repeat (60) cycle();
        end
        drain("random");

        // reset in the middle of owner 2's tenure
        do_reset("rst_c");
        for (int i = 0; i < N; i++) begin fill(i, 8, -1); rate[i] = 100; end
        g = 0;
        while (!(m_busy && m_owner == 2 && m_beats >= 1) && g < 200) begin cycle(); g++; end
        chk("reach_owner2", 32'(g < 200), 1);
        do_reset("rst_mid");
        wlog.delete(); wcyc.delete();
        drain("after_rst");
        chk("after_rst_first_owner", 32'(wlog.size() > 0 ? wlog[0] : -1), 0);
        chk("after_rst_wr_count", 32'(wr_count), 32'(wlog.size()));
        chk("exp_q_leftover", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
